serial_addsub: RTL and testbench

Parametrised, digit-serial signed/unsigned add/subtract unit with valid/ready handshakes on input and output. It processes DIGIT bits per clock, LSB digit first, and reports carry/borrow, signed overflow and zero flags. It generalises the fixed 4-bit combinational subtractor to any width, adds an add/sub mode and borrow-in, and trades latency for area. It sits between the operand register file and the ALU result mux.

---
 rtl/serial_addsub_pkg.sv | 18 +
 rtl/serial_addsub_digit.sv | 24 ++
 rtl/serial_addsub.sv | 128 ++++++++++++
 tb/tb_serial_addsub.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial add/subtract unit: op encoding,
// FSM state type and the parameter legality helper.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } stateT;

  function automatic bit digitDivides(int unsigned width, int unsigned digit);
    return (digit != 0) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// DIGIT-bit ripple-carry adder slice used by the serial datapath.
module addsub_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial signed/unsigned add/subtract unit with valid/ready handshakes.
// Optional saturation on signed overflow: define SERIAL_ADDSUB_SAT_EN.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH < 2) || !digitDivides(WIDTH, DIGIT)) begin : gBadParams
    $error("serial_addsub: WIDTH must be >= 2 and divisible by DIGIT");
  end

  stateT state, nextState;

  logic [WIDTH-1:0] aReg, bReg, bEff, ySum, yFinal;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dSum;
  logic             carry, dCout, aMsb, bMsb, accept, lastDigit, ovfNext;

  assign bEff      = (op == OP_SUB) ? ~b : b;
  assign accept    = (state == IDLE) && in_valid;
  assign lastDigit = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nextState = CALC;
      end
      CALC: if (lastDigit) nextState = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  addsub_digit #(.DIGIT(DIGIT)) uDigit (
    .x   (aReg[DIGIT-1:0]),
    .y   (bReg[DIGIT-1:0]),
    .cin (carry),
    .s   (dSum),
    .cout(dCout)
  );

  // Digit sums enter at the top; after NDIG digits the full result is aligned.
  if (NDIG == 1) begin : gSingle
    assign ySum = dSum;
  end else begin : gMulti
    logic [WIDTH-DIGIT-1:0] yAcc;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 yAcc <= '0;
      else if (accept)         yAcc <= '0;
      else if (state == CALC)  yAcc <= ySum[WIDTH-1:DIGIT];
    end
    assign ySum = {dSum, yAcc};
  end

  assign ovfNext = (aMsb == bMsb) && (ySum[WIDTH-1] != aMsb);

`ifdef SERIAL_ADDSUB_SAT_EN
  assign yFinal = ovfNext ? {aMsb, {(WIDTH-1){~aMsb}}} : ySum;
`else
  assign yFinal = ySum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg      <= '0;
      bReg      <= '0;
      carry     <= 1'b0;
      aMsb      <= 1'b0;
      bMsb      <= 1'b0;
      cnt       <= '0;
      y         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      aReg  <= a;
      bReg  <= bEff;
      carry <= (op == OP_SUB) ? ~carry_in : carry_in;
      aMsb  <= a[WIDTH-1];
      bMsb  <= bEff[WIDTH-1];
      cnt   <= '0;
    end else if (state == CALC) begin
      aReg  <= aReg >> DIGIT;
      bReg  <= bReg >> DIGIT;
      carry <= dCout;
      cnt   <= cnt + 1'b1;
      if (lastDigit) begin
        y         <= yFinal;
        carry_out <= dCout;
        overflow  <= ovfNext;
        zero      <= (yFinal == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=16, DIGIT=4): directed vectors
// with literal expectations plus an arithmetic reference model checked every cycle.
module tb_serial_addsub;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int NDIG = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, op, carry_in, out_valid, out_ready;
  logic carry_out, overflow, zero;
  logic [WIDTH-1:0] a, b, y;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] y;
    logic        c;
    logic        v;
    logic        z;
  } resT;

  resT expQ[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic resT model(logic [15:0] av, logic [15:0] bv, logic opv, logic cinv);
    resT r;
    int sa, sb, ua, ub, ci, sres;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = int'(av);
    ub = int'(bv);
    ci = cinv ? 1 : 0;
    if (!opv) begin
      sres = sa + sb + ci;
      r.c  = (ua + ub + ci) > 65535;
    end else begin
      sres = sa - sb - ci;
      r.c  = ua >= (ub + ci);
    end
    r.v = (sres > 32767) || (sres < -32768);
    r.y = sres[15:0];
`ifdef SERIAL_ADDSUB_SAT_EN
    if (r.v) r.y = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
    r.z = (r.y == 16'h0000);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready && expQ.size() > 0) void'(expQ.pop_front());
      if (in_valid && in_ready) expQ.push_back(model(a, b, op, carry_in));
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_result: out_valid with y=%0h but no accepted operation pending", y);
      end else begin
        check("model_y", y, expQ[0].y);
        check("model_carry", carry_out, expQ[0].c);
        check("model_ovf", overflow, expQ[0].v);
        check("model_zero", zero, expQ[0].z);
        check("model_inready", in_ready, 1'b0);
      end
    end
  end

  task automatic runOp(string name, logic [15:0] av, logic [15:0] bv, logic opv, logic cinv,
                       logic [15:0] ey, logic ec, logic ev, logic ez);
    int n;
    @(negedge clk);
    a = av; b = bv; op = opv; carry_in = cinv; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({name, "_inready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; op = ~opv; carry_in = ~cinv;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, n, NDIG);
    check({name, "_y"}, y, ey);
    check({name, "_carry"}, carry_out, ec);
    check({name, "_ovf"}, overflow, ev);
    check({name, "_zero"}, zero, ez);
    @(posedge clk); #1;
    check({name, "_done_valid"}, out_valid, 1'b0);
    check({name, "_done_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; carry_in = 1'b0;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_inready", in_ready, 1'b1);
    check("reset_outvalid", out_valid, 1'b0);
    check("reset_y", y, 16'h0000);
    check("reset_flags", {carry_out, overflow, zero}, 3'b000);
    rst = 1'b0;

    runOp("sub5m3", 16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    runOp("sub5m3b", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    runOp("addwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef SERIAL_ADDSUB_SAT_EN
    runOp("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    runOp("negovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    runOp("negadd", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    runOp("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    runOp("negovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    runOp("negadd", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
`endif
    runOp("borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Backpressure with new operands waiting.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; op = 1'b0; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'h0100; b = 16'h0001;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_latency", n, NDIG);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_y", y, 16'h2345);
      check("bp_flags", {carry_out, overflow, zero}, 3'b000);
      check("bp_inready", in_ready, 1'b0);
      check("bp_outvalid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_inready", in_ready, 1'b1);
    check("bp_release_outvalid", out_valid, 1'b0);
    @(posedge clk); #1;
    check("bp_queued_accept", in_ready, 1'b0);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_queued_latency", n, NDIG);
    check("bp_queued_y", y, 16'h0101);
    @(posedge clk); #1;

    // Reset in the second CALC cycle.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op = 1'b0; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_outvalid", out_valid, 1'b0);
    check("midrst_inready", in_ready, 1'b1);
    check("midrst_y", y, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_result", out_valid, 1'b0);
    end
    runOp("postrst", 16'h0010, 16'h0020, 1'b1, 1'b0, 16'hFFF0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
